// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: dekatron-derived bus widths,
// FSM state encoding and the tie-break rule between the two requesters.
package ram_port_arbiter_pkg;

  localparam int AP_DEKATRON_NUM   = 5;
  localparam int DATA_DEKATRON_NUM = 3;
  localparam int DEKATRON_WIDTH    = 4;

  localparam int ARB_ADDR_WIDTH = AP_DEKATRON_NUM * DEKATRON_WIDTH;
  localparam int ARB_DATA_WIDTH = DATA_DEKATRON_NUM * DEKATRON_WIDTH;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_PAN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  // On a tie the port that did not win last time is served.
  function automatic logic pick_port(input logic cpu_pend,
                                     input logic pan_pend,
                                     input logic last_grant);
    logic sel;
    if (cpu_pend && pan_pend) sel = ~last_grant;
    else if (pan_pend)        sel = GRANT_PAN;
    else                      sel = GRANT_CPU;
    return sel;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of CPU, panel and RAM-side signals around the arbiter. The master
// side is the requesters plus the RAM; the slave side is the arbiter itself.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
) ();

  logic                  CpuReq;
  logic                  CpuWE;
  logic [ADDR_WIDTH-1:0] CpuAddr;
  logic [DATA_WIDTH-1:0] CpuDataIn;
  logic [DATA_WIDTH-1:0] CpuDataOut;
  logic                  CpuReady;

  logic                  PanReq;
  logic                  PanWE;
  logic [ADDR_WIDTH-1:0] PanAddr;
  logic [DATA_WIDTH-1:0] PanDataIn;
  logic [DATA_WIDTH-1:0] PanDataOut;
  logic                  PanReady;

  logic [ADDR_WIDTH-1:0] RamAddr;
  logic [DATA_WIDTH-1:0] RamIn;
  logic [DATA_WIDTH-1:0] RamOut;
  logic                  RamCS;
  logic                  RamWE;

  logic                  Busy;
  logic                  Grant;

  modport master (
    output CpuReq, CpuWE, CpuAddr, CpuDataIn,
    input  CpuDataOut, CpuReady,
    output PanReq, PanWE, PanAddr, PanDataIn,
    input  PanDataOut, PanReady,
    input  RamAddr, RamIn, RamCS, RamWE,
    output RamOut,
    input  Busy, Grant
  );

  modport slave (
    input  CpuReq, CpuWE, CpuAddr, CpuDataIn,
    output CpuDataOut, CpuReady,
    input  PanReq, PanWE, PanAddr, PanDataIn,
    output PanDataOut, PanReady,
    output RamAddr, RamIn, RamCS, RamWE,
    input  RamOut,
    output Busy, Grant
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port RAM arbiter: the CPU and the front-panel loader share one RAM port,
// alternating on simultaneous requests and serving each Req level only once.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = ARB_DATA_WIDTH,
  parameter int RAM_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  ram_port_arbiter_if.slave bus
);

  // Last WAIT count value; WAIT is skipped entirely for a single-cycle RAM.
  localparam logic [1:0] WAIT_LAST = (RAM_LATENCY > 1) ? 2'(RAM_LATENCY - 2) : 2'd0;

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [1:0]            r_wait_cnt;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_cpu_armed;
  logic                  r_pan_armed;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [DATA_WIDTH-1:0] r_cpu_dout;
  logic [DATA_WIDTH-1:0] r_pan_dout;
  logic                  r_cpu_ready;
  logic                  r_pan_ready;

  logic                  w_cpu_pend;
  logic                  w_pan_pend;
  logic                  w_start;
  logic                  w_pick;
  logic                  w_wait_last;
  logic                  w_done_cpu;
  logic                  w_done_pan;

  assign w_cpu_pend  = bus.CpuReq & r_cpu_armed;
  assign w_pan_pend  = bus.PanReq & r_pan_armed;
  assign w_start     = (r_state == ST_IDLE) & (w_cpu_pend | w_pan_pend);
  assign w_pick      = pick_port(w_cpu_pend, w_pan_pend, r_last_grant);
  assign w_wait_last = (r_wait_cnt == WAIT_LAST);
  assign w_done_cpu  = (r_state == ST_DONE) & (r_grant == GRANT_CPU);
  assign w_done_pan  = (r_state == ST_DONE) & (r_grant == GRANT_PAN);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_cpu_pend || w_pan_pend) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = (RAM_LATENCY > 1) ? ST_WAIT : ST_DONE;
      ST_WAIT:   if (w_wait_last) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.RamCS = 1'b0;
    bus.RamWE = 1'b0;
    if (r_state == ST_ACCESS) begin
      bus.RamCS = 1'b1;
      bus.RamWE = r_we;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wait_cnt <= 2'd0;
    end else if (r_state == ST_ACCESS) begin
      r_wait_cnt <= 2'd0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 2'd1;
    end
  end

  // Request is captured once at grant; later requester activity is ignored.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_grant <= GRANT_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else if (w_start) begin
      r_grant <= w_pick;
      if (w_pick == GRANT_PAN) begin
        r_we   <= bus.PanWE;
        r_addr <= bus.PanAddr;
        r_din  <= bus.PanDataIn;
      end else begin
        r_we   <= bus.CpuWE;
        r_addr <= bus.CpuAddr;
        r_din  <= bus.CpuDataIn;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_last_grant <= GRANT_PAN;
      r_cpu_ready  <= 1'b0;
      r_pan_ready  <= 1'b0;
      r_cpu_dout   <= '0;
      r_pan_dout   <= '0;
    end else begin
      r_cpu_ready <= w_done_cpu;
      r_pan_ready <= w_done_pan;
      if (r_state == ST_DONE) r_last_grant <= r_grant;
      if (w_done_cpu && !r_we) r_cpu_dout <= bus.RamOut;
      if (w_done_pan && !r_we) r_pan_dout <= bus.RamOut;
    end
  end

  // A port re-arms only after its Req has been seen low, so a held Req is served once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cpu_armed <= 1'b1;
      r_pan_armed <= 1'b1;
    end else begin
      if (w_done_cpu)       r_cpu_armed <= 1'b0;
      else if (!bus.CpuReq) r_cpu_armed <= 1'b1;
      if (w_done_pan)       r_pan_armed <= 1'b0;
      else if (!bus.PanReq) r_pan_armed <= 1'b1;
    end
  end

  assign bus.RamAddr    = r_addr;
  assign bus.RamIn      = r_din;
  assign bus.Busy       = (r_state != ST_IDLE);
  assign bus.Grant      = r_grant;
  assign bus.CpuDataOut = r_cpu_dout;
  assign bus.PanDataOut = r_pan_dout;
  assign bus.CpuReady   = r_cpu_ready;
  assign bus.PanReady   = r_pan_ready;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance with a 1-cycle RAM and one
// with a 3-cycle RAM, each backed by a small behavioural RAM.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW = ARB_ADDR_WIDTH;
  localparam int DW = ARB_DATA_WIDTH;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst_n1;
  logic Rst_n3;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b3 ();

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n1), .bus(b1)
  );
  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(3)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n3), .bus(b3)
  );

  // RAM models: read data appears RAM_LATENCY edges after the RamCS cycle.
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] ram1_q  = '0;
  logic [DW-1:0] ram3_p0 = '0;
  logic [DW-1:0] ram3_p1 = '0;
  logic [DW-1:0] ram3_p2 = '0;

  always @(posedge Clk) begin
    if (b1.RamCS && b1.RamWE)  mem1[b1.RamAddr] <= b1.RamIn;
    if (b1.RamCS && !b1.RamWE) ram1_q <= mem1[b1.RamAddr];
  end

  always @(posedge Clk) begin
    if (b3.RamCS && b3.RamWE)  mem3[b3.RamAddr] <= b3.RamIn;
    if (b3.RamCS && !b3.RamWE) ram3_p0 <= mem3[b3.RamAddr];
    ram3_p1 <= ram3_p0;
    ram3_p2 <= ram3_p1;
  end

  assign b1.RamOut = ram1_q;
  assign b3.RamOut = ram3_p2;

  int cs1_n = 0, crdy1_n = 0, prdy1_n = 0;
  int cs3_n = 0, crdy3_n = 0;
  always @(posedge Clk) begin
    if (b1.RamCS)    cs1_n   <= cs1_n + 1;
    if (b1.CpuReady) crdy1_n <= crdy1_n + 1;
    if (b1.PanReady) prdy1_n <= prdy1_n + 1;
    if (b3.RamCS)    cs3_n   <= cs3_n + 1;
    if (b3.CpuReady) crdy3_n <= crdy3_n + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat);
    @(negedge Clk);
    b1.CpuReq = 1'b1; b1.CpuWE = we; b1.CpuAddr = a; b1.CpuDataIn = d;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (b1.CpuReady) begin lat = k; break; end
    end
    b1.CpuReq = 1'b0;
  endtask

  task automatic cpu3(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat);
    @(negedge Clk);
    b3.CpuReq = 1'b1; b3.CpuWE = we; b3.CpuAddr = a; b3.CpuDataIn = d;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (b3.CpuReady) begin lat = k; break; end
    end
    b3.CpuReq = 1'b0;
  endtask

  task automatic pan3(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat);
    @(negedge Clk);
    b3.PanReq = 1'b1; b3.PanWE = we; b3.PanAddr = a; b3.PanDataIn = d;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (b3.PanReady) begin lat = k; break; end
    end
    b3.PanReq = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 1ms");
    $fatal(1);
  end

  initial begin
    int lat, c_cs, c_cr, c_pr, cr_at, pr_at;
    logic g1, g2;

    b1.CpuReq = 0; b1.CpuWE = 0; b1.CpuAddr = '0; b1.CpuDataIn = '0;
    b1.PanReq = 0; b1.PanWE = 0; b1.PanAddr = '0; b1.PanDataIn = '0;
    b3.CpuReq = 0; b3.CpuWE = 0; b3.CpuAddr = '0; b3.CpuDataIn = '0;
    b3.PanReq = 0; b3.PanWE = 0; b3.PanAddr = '0; b3.PanDataIn = '0;
    Rst_n1 = 1'b0;
    Rst_n3 = 1'b0;
    repeat (3) @(negedge Clk);

    chk("rst_busy_grant", 32'({b1.Busy, b1.Grant}), 32'h0);
    chk("rst_cs_we", 32'({b1.RamCS, b1.RamWE}), 32'h0);
    chk("rst_ready", 32'({b1.CpuReady, b1.PanReady}), 32'h0);
    chk("rst_ramaddr", 32'(b1.RamAddr), 32'h0);
    chk("rst_dout", 32'({b1.CpuDataOut, b1.PanDataOut}), 32'h0);
    Rst_n1 = 1'b1;
    Rst_n3 = 1'b1;

    // CPU write then read back, latency 1
    c_cs = cs1_n; c_cr = crdy1_n;
    cpu1(1'b1, 20'h00042, 12'h123, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    cpu1(1'b0, 20'h00042, 12'h000, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(b1.CpuDataOut), 32'h123);
    @(negedge Clk);
    chk("wr_rd_cs_count", 32'(cs1_n - c_cs), 32'd2);
    chk("wr_rd_ready_count", 32'(crdy1_n - c_cr), 32'd2);

    // Simultaneous requests right after reset: CPU wins the first tie
    Rst_n1 = 1'b0;
    @(negedge Clk);
    Rst_n1 = 1'b1;
    @(negedge Clk);
    c_cs = cs1_n; c_cr = crdy1_n; c_pr = prdy1_n;
    b1.CpuReq = 1; b1.CpuWE = 0; b1.CpuAddr = 20'h00042;
    b1.PanReq = 1; b1.PanWE = 1; b1.PanAddr = 20'h00007; b1.PanDataIn = 12'h555;
    cr_at = -1; pr_at = -1; g1 = 1'bx; g2 = 1'bx;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      if (b1.CpuReady && cr_at < 0) cr_at = k;
      if (b1.PanReady && pr_at < 0) pr_at = k;
      if (k == 1) g1 = b1.Grant;
      if (k == 4) g2 = b1.Grant;
    end
    b1.CpuReq = 0; b1.PanReq = 0;
    chk("tie_cpu_ready_at", 32'(cr_at), 32'd3);
    chk("tie_pan_ready_at", 32'(pr_at), 32'd6);
    chk("tie_grant_first", 32'(g1), 32'd0);
    chk("tie_grant_second", 32'(g2), 32'd1);
    chk("tie_cpu_data", 32'(b1.CpuDataOut), 32'h123);
    chk("tie_pan_dout_hold", 32'(b1.PanDataOut), 32'h0);
    chk("tie_cs_count", 32'(cs1_n - c_cs), 32'd2);
    chk("tie_ready_counts", 32'({16'(crdy1_n - c_cr), 16'(prdy1_n - c_pr)}), 32'h0001_0001);

    // CPU Req held high for 20 cycles: one access only
    @(negedge Clk);
    c_cs = cs1_n; c_cr = crdy1_n;
    b1.CpuReq = 1; b1.CpuWE = 0; b1.CpuAddr = 20'h00007;
    repeat (20) @(negedge Clk);
    b1.CpuReq = 0;
    chk("hold_cs_count", 32'(cs1_n - c_cs), 32'd1);
    chk("hold_ready_count", 32'(crdy1_n - c_cr), 32'd1);
    chk("hold_data", 32'(b1.CpuDataOut), 32'h555);

    // Requester changes address/data right after grant
    @(negedge Clk);
    b1.CpuReq = 1; b1.CpuWE = 1; b1.CpuAddr = 20'h00010; b1.CpuDataIn = 12'h456;
    @(posedge Clk);
    #1;
    b1.CpuAddr = 20'h00020; b1.CpuDataIn = 12'h777;
    @(negedge Clk);
    chk("latch_cs_we", 32'({b1.RamCS, b1.RamWE, b1.Busy}), 32'h7);
    chk("latch_addr", 32'(b1.RamAddr), 32'h00010);
    chk("latch_din", 32'(b1.RamIn), 32'h456);
    lat = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge Clk);
      if (b1.CpuReady) begin lat = k; break; end
    end
    b1.CpuReq = 0;
    chk("latch_lat", 32'(lat), 32'd3);
    cpu1(1'b0, 20'h00010, 12'h000, lat);
    chk("latch_readback", 32'(b1.CpuDataOut), 32'h456);

    // Latency-3 RAM: CPU write/read, then panel write to the top address
    cpu3(1'b1, 20'h00005, 12'hABC, lat);
    chk("l3_wr_lat", 32'(lat), 32'd5);
    cpu3(1'b0, 20'h00005, 12'h000, lat);
    chk("l3_rd_lat", 32'(lat), 32'd5);
    chk("l3_rd_data", 32'(b3.CpuDataOut), 32'hABC);
    @(negedge Clk);
    c_cs = cs3_n;
    pan3(1'b1, 20'hFFFFF, 12'h999, lat);
    @(negedge Clk);
    chk("l3_pan_wr_lat", 32'(lat), 32'd5);
    chk("l3_pan_cs_count", 32'(cs3_n - c_cs), 32'd1);
    chk("l3_cpu_dout_hold", 32'(b3.CpuDataOut), 32'hABC);
    chk("l3_pan_dout_on_wr", 32'(b3.PanDataOut), 32'h0);
    pan3(1'b0, 20'hFFFFF, 12'h000, lat);
    chk("l3_pan_rd_lat", 32'(lat), 32'd5);
    chk("l3_pan_rd_data", 32'(b3.PanDataOut), 32'h999);

    // Reset while the latency-3 access sits in WAIT
    @(negedge Clk);
    c_cr = crdy3_n;
    b3.CpuReq = 1; b3.CpuWE = 0; b3.CpuAddr = 20'h00005;
    @(negedge Clk);
    chk("abort_access_cs", 32'(b3.RamCS), 32'd1);
    @(negedge Clk);
    chk("abort_wait_busy", 32'({b3.Busy, b3.RamCS}), 32'h2);
    Rst_n3 = 1'b0;
    #1;
    chk("abort_busy_cs", 32'({b3.Busy, b3.RamCS, b3.RamWE}), 32'h0);
    chk("abort_dout_cleared", 32'(b3.CpuDataOut), 32'h0);
    b3.CpuReq = 0;
    repeat (2) @(negedge Clk);
    Rst_n3 = 1'b1;
    repeat (4) @(negedge Clk);
    chk("abort_no_ready", 32'(crdy3_n - c_cr), 32'd0);
    cpu3(1'b0, 20'h00005, 12'h000, lat);
    chk("abort_next_lat", 32'(lat), 32'd5);
    chk("abort_next_data", 32'(b3.CpuDataOut), 32'hABC);

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, RAM address width (5 dekatrons x 4 bits).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, RAM data width (3 dekatrons x 4 bits).
REQ-003 SHALL have parameter RAM_LATENCY, default 1, cycles from RamCS to valid RamOut; legal range 1-3.
REQ-004 SHALL have ports Clk in 1 clock; Rst_n in 1 reset, asynchronous, active-low.
REQ-005 SHALL have CPU port: CpuReq in 1, CpuWE in 1, CpuAddr in ADDR_WIDTH, CpuDataIn in DATA_WIDTH, CpuDataOut out DATA_WIDTH, CpuReady out 1.
REQ-006 SHALL have panel/loader port: PanReq in 1, PanWE in 1, PanAddr in ADDR_WIDTH, PanDataIn in DATA_WIDTH, PanDataOut out DATA_WIDTH, PanReady out 1.
REQ-007 SHALL have RAM port: RamAddr out ADDR_WIDTH, RamIn out DATA_WIDTH, RamOut in DATA_WIDTH, RamCS out 1, RamWE out 1.
REQ-008 SHALL have Busy out 1 (access in flight) and Grant out 1 (0 = CPU, 1 = panel, valid while Busy).

Function
REQ-009 Req is level; a port is "pending" when Req=1 and its armed flag=1.
REQ-010 FSM states: IDLE, ACCESS, WAIT, DONE.
REQ-011 IDLE: if no port pending, stay; otherwise grant, latch that port's Addr/DataIn/WE, go ACCESS.
REQ-012 Both pending in same cycle: grant the port NOT granted last; the last-grant register resets to panel, so the first tie goes to CPU.
REQ-013 ACCESS: exactly one cycle, RamCS=1, RamWE=latched WE, RamAddr/RamIn=latched values; then WAIT.
REQ-014 WAIT: count RAM_LATENCY-1 further cycles (0 for latency 1), then DONE.
REQ-015 DONE: capture RamOut into granted port's DataOut on reads; DataOut is unchanged on writes; one-cycle Ready pulse to granted port; clear its armed flag; update last-grant; go IDLE.
REQ-016 Latency Req-to-Ready for idle arbiter = RAM_LATENCY+2 cycles; back-to-back grants are separated by one IDLE cycle.
REQ-017 Armed flag re-sets when that port's Req is sampled 0; Req held high across Ready SHALL NOT cause a second access.
REQ-018 Req dropped during ACCESS/WAIT/DONE: access completes, Ready still pulses, flag cleared.
REQ-019 Latched inputs SHALL be immune to requester changes after grant.
REQ-020 RamCS and RamWE SHALL be 0 in every state except ACCESS; RamAddr/RamIn hold last latched values elsewhere.
REQ-021 Ungranted port's Ready SHALL stay 0; its DataOut holds.
REQ-022 Busy=1 in ACCESS, WAIT, DONE.

Reset
REQ-023 Rst_n low SHALL asynchronously force IDLE, RamCS=0, RamWE=0, CpuReady=0, PanReady=0, Busy=0, Grant=0, DataOuts=0, RamAddr=0, RamIn=0, both armed flags=1, last-grant=panel.
REQ-024 Reset mid-access SHALL abort it with no Ready pulse; the RAM write may or may not have occurred and is not relied upon.

Structure
REQ-025 Default ADDR_WIDTH/DATA_WIDTH derive from AP_DEKATRON_NUM, DATA_DEKATRON_NUM, DEKATRON_WIDTH in the shared package; the FSM state enum SHALL also live there.
REQ-026 Single module, no sub-modules; the latency counter is inline.

Verification
REQ-027 Bench SHALL cover: CPU write 0x123 to addr 0x00042, then CPU read 0x00042 -> CpuDataOut=0x123, CpuReady pulses once per access, 3 cycles Req-to-Ready (latency 1).
REQ-028 Bench SHALL cover: CpuReq and PanReq rise same cycle after reset -> CPU served first, panel second, Grant 0 then 1, PanReady 3 cycles after CpuReady.
REQ-029 Bench SHALL cover: CpuReq held high for 20 cycles -> exactly one RamCS pulse and one CpuReady.
REQ-030 Bench SHALL cover: panel write 0x999 to 0xFFFFF with RAM_LATENCY=3 -> RamCS one cycle, PanReady 5 cycles after Req, CpuDataOut unchanged.
REQ-031 Bench SHALL cover: Rst_n asserted during WAIT -> RamCS=0 and Busy=0 immediately; no Ready pulse; next CpuReq served normally.
REQ-032 Bench SHALL cover: CPU changes CpuAddr from 0x00010 to 0x00020 one cycle after grant -> RamAddr=0x00010 during ACCESS.
